// File: rtl/beat_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and constants for the beat sequencer:
//   seq_state_t  - sequencer FSM state encoding
//   DEF_BEAT_W   - default beat counter width
//   TRACK_LEN    - length in beats of each selectable track (track 0..3)
//   track_len()  - length lookup for a track index
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } seq_state_t;

   localparam int DEF_BEAT_W = 12;

   localparam int NUM_TRACK_LEN = 4;
   localparam int unsigned TRACK_LEN [NUM_TRACK_LEN] = '{1200, 64, 512, 256};

   // Only the low two bits select a table entry; the table has four tracks.
   function automatic int unsigned track_len(input int unsigned idx);
      return TRACK_LEN[idx[1:0]];
   endfunction

endpackage

// File: rtl/beat_sequencer_if.sv
// -----------------------------------------------------------------------------
// beat_sequencer_if
// Control and output bundle of the beat sequencer.
//   master : drives play/pause/loop/track_sel/tempo/vol_in, observes outputs
//   slave  : the sequencer; drives beat_num/track/en/volume/done
// Parameters: BEAT_W (beat width), NUM_TRACKS (track count), TEMPO_W (tempo width)
// -----------------------------------------------------------------------------
interface beat_sequencer_if #(
   parameter int BEAT_W     = 12,
   parameter int NUM_TRACKS = 4,
   parameter int TEMPO_W    = 3
);
   localparam int TW = $clog2(NUM_TRACKS);

   logic               play;
   logic               pause;
   logic               loop;
   logic [TW-1:0]      track_sel;
   logic [TEMPO_W-1:0] tempo;
   logic [1:0]         vol_in;

   logic [BEAT_W-1:0]  beat_num;
   logic [TW-1:0]      track;
   logic               en;
   logic [1:0]         volume;
   logic               done;

   modport master (
      output play, pause, loop, track_sel, tempo, vol_in,
      input  beat_num, track, en, volume, done
   );

   modport slave (
      input  play, pause, loop, track_sel, tempo, vol_in,
      output beat_num, track, en, volume, done
   );

endinterface

// File: rtl/beat_sequencer_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Parametrised-width two-flop synchroniser with asynchronous active-high reset.
//   clk22 : destination clock
//   rst   : async reset, clears both stages
//   i_d   : asynchronous input bus
//   o_q   : synchronised output bus (two clk22 edges of latency)
// -----------------------------------------------------------------------------
module sync2 #(
   parameter int W = 1
) (
   input  logic         clk22,
   input  logic         rst,
   input  logic [W-1:0] i_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;

   always_ff @(posedge clk22 or posedge rst) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/beat_sequencer.sv
// -----------------------------------------------------------------------------
// beat_sequencer
// Beat-index sequencer on the slow clk22 tick: track select, play/pause/stop,
// loop or one-shot, tempo prescaler and an end-of-track done pulse. Feeds the
// music ROM (beat_num, track, en) and the note generator (volume).
//   clk22 : slow beat clock
//   rst   : asynchronous, active-high reset
//   bus   : beat_sequencer_if.slave (controls in, beat/track/en/volume/done out)
// Build option: define SEQ_FADE_EN to ramp volume down over the last
// FADE_BEATS beats of a one-shot track.
//
// state | meaning
// IDLE  | stopped, beat held at 0, tone off
// PLAY  | running, beat advances every tempo+1 cycles, tone on
// PAUSE | beat and prescaler frozen, tone off
// DONE  | one-shot finished, beat held at last index until play drops
// -----------------------------------------------------------------------------
module beat_sequencer
   import seq_pkg::*;
#(
   parameter int BEAT_W     = DEF_BEAT_W,
   parameter int NUM_TRACKS = 4,
   parameter int TEMPO_W    = 3,
   parameter int FADE_BEATS = 16
) (
   input  logic            clk22,
   input  logic            rst,
   beat_sequencer_if.slave bus
);

   localparam int TW = $clog2(NUM_TRACKS);
   localparam int SW = 3 + TW + TEMPO_W + 2;

   logic [SW-1:0]      w_sync_in;
   logic [SW-1:0]      w_sync_out;
   logic               w_play_s;
   logic               w_pause_s;
   logic               w_loop_s;
   logic [TW-1:0]      w_track_sel_s;
   logic [TEMPO_W-1:0] w_tempo_s;
   logic [1:0]         w_vol_in_s;

   seq_state_t         r_state;
   logic [BEAT_W-1:0]  r_beat;
   logic [TW-1:0]      r_track;
   logic [TEMPO_W-1:0] r_presc;
   logic               r_done;

   seq_state_t         w_state_nxt;
   logic [BEAT_W-1:0]  w_beat_nxt;
   logic [TW-1:0]      w_track_nxt;
   logic [TEMPO_W-1:0] w_presc_nxt;
   logic               w_done_nxt;

   logic [BEAT_W-1:0]  w_beat_last;
   logic [1:0]         w_volume;

   assign w_sync_in = {bus.play, bus.pause, bus.loop, bus.track_sel, bus.tempo, bus.vol_in};

   sync2 #(.W(SW)) u_sync (
      .clk22 (clk22),
      .rst   (rst),
      .i_d   (w_sync_in),
      .o_q   (w_sync_out)
   );

   assign {w_play_s, w_pause_s, w_loop_s, w_track_sel_s, w_tempo_s, w_vol_in_s} = w_sync_out;

   assign w_beat_last = BEAT_W'(track_len(32'(r_track)) - 32'd1);

   always_ff @(posedge clk22 or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_beat  <= '0;
         r_track <= '0;
         r_presc <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_track <= w_track_nxt;
         r_presc <= w_presc_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_track_nxt = r_track;
      w_presc_nxt = r_presc;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_beat_nxt  = '0;
            w_presc_nxt = '0;
            if (w_play_s) begin
               w_state_nxt = ST_PLAY;
               w_track_nxt = w_track_sel_s;
            end
         end
         ST_PLAY: begin
            if (!w_play_s) begin
               w_state_nxt = ST_IDLE;
               w_beat_nxt  = '0;
               w_presc_nxt = '0;
            end else if (w_track_sel_s != r_track) begin
               // Restart on the new track; this also overrides an end-of-track
               // advance in the same cycle, so no done pulse is produced.
               w_track_nxt = w_track_sel_s;
               w_beat_nxt  = '0;
               w_presc_nxt = '0;
            end else if (w_pause_s) begin
               w_state_nxt = ST_PAUSE;
            end else if (r_presc >= w_tempo_s) begin
               // >= rather than == so a tempo lowered mid-beat still advances.
               w_presc_nxt = '0;
               if (r_beat >= w_beat_last) begin
                  w_done_nxt = 1'b1;
                  if (w_loop_s) begin
                     w_beat_nxt = '0;
                  end else begin
                     w_state_nxt = ST_DONE;
                     w_beat_nxt  = w_beat_last;
                  end
               end else begin
                  w_beat_nxt = r_beat + BEAT_W'(1);
               end
            end else begin
               w_presc_nxt = r_presc + TEMPO_W'(1);
            end
         end
         ST_PAUSE: begin
            if (!w_play_s) begin
               w_state_nxt = ST_IDLE;
               w_beat_nxt  = '0;
               w_presc_nxt = '0;
            end else if (!w_pause_s) begin
               w_state_nxt = ST_PLAY;
            end
         end
         ST_DONE: begin
            w_beat_nxt = w_beat_last;
            if (!w_play_s) begin
               w_state_nxt = ST_IDLE;
               w_beat_nxt  = '0;
               w_presc_nxt = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_beat_nxt  = '0;
            w_presc_nxt = '0;
         end
      endcase
   end

`ifdef SEQ_FADE_EN
   // Window position counts up 0..FADE_BEATS-1 towards the last beat; each
   // quarter of the window removes one volume step.
   localparam int FADE_SH = $clog2(FADE_BEATS) - 2;

   logic [BEAT_W-1:0] w_remain;
   logic [BEAT_W-1:0] w_fade_pos;
   logic [1:0]        w_step;

   assign w_remain   = w_beat_last - r_beat;
   assign w_fade_pos = BEAT_W'(FADE_BEATS - 1) - w_remain;

   always_comb begin
      w_volume = w_vol_in_s;
      w_step   = 2'd0;
      if (r_state == ST_PLAY && !w_loop_s && w_remain < BEAT_W'(FADE_BEATS)) begin
         w_step   = 2'(w_fade_pos >> FADE_SH);
         w_volume = (w_step >= w_vol_in_s) ? 2'd0 : (w_vol_in_s - w_step);
      end
   end
`else
   // Fade window length is meaningless without the fade option.
   localparam int unused_fade_beats = FADE_BEATS;

   assign w_volume = w_vol_in_s;
`endif

   assign bus.beat_num = r_beat;
   assign bus.track    = r_track;
   assign bus.en       = (r_state == ST_PLAY);
   assign bus.done     = r_done;
   assign bus.volume   = w_volume;

endmodule

// File: tb/tb_beat_sequencer.sv
// -----------------------------------------------------------------------------
// tb_beat_sequencer
// Directed bench for beat_sequencer. Each step pushes the outputs it expects
// for future cycles onto a scoreboard queue; after every clk22 edge the due
// entries are popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_beat_sequencer;

   localparam int BEAT_W     = 12;
   localparam int NUM_TRACKS = 4;
   localparam int TEMPO_W    = 3;

`ifdef SEQ_FADE_EN
   localparam bit FADE_ON = 1'b1;
`else
   localparam bit FADE_ON = 1'b0;
`endif

   typedef struct {
      int    cyc;
      string tag;
      int    beat;
      int    trk;
      bit    en;
      bit    dn;
      int    vol;
   } exp_t;

   logic clk22;
   logic rst;
   int   cyc;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   beat_sequencer_if #(.BEAT_W(BEAT_W), .NUM_TRACKS(NUM_TRACKS), .TEMPO_W(TEMPO_W)) bus ();

   beat_sequencer #(
      .BEAT_W     (BEAT_W),
      .NUM_TRACKS (NUM_TRACKS),
      .TEMPO_W    (TEMPO_W),
      .FADE_BEATS (16)
   ) dut (
      .clk22 (clk22),
      .rst   (rst),
      .bus   (bus)
   );

   initial clk22 = 1'b0;
   always #5 clk22 = ~clk22;

   // Expected volume from the requested volume and play position.
   function automatic int fv(input int vol, input int beat, input int last,
                             input bit lp, input bit playing);
      int r;
      int step;
      r    = last - beat;
      step = 0;
      if (FADE_ON && playing && !lp && r < 16) step = (15 - r) / 4;
      return (vol > step) ? (vol - step) : 0;
   endfunction

   task automatic push(input int dc, input string tag, input int beat, input int trk,
                       input bit en, input bit dn, input int vol);
      exp_t e;
      e.cyc  = cyc + dc;
      e.tag  = tag;
      e.beat = beat;
      e.trk  = trk;
      e.en   = en;
      e.dn   = dn;
      e.vol  = vol;
      sb.push_back(e);
   endtask

   task automatic check_due();
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t        e;
         logic [17:0] obs;
         logic [17:0] exv;
         e   = sb.pop_front();
         obs = {bus.beat_num, bus.track, bus.en, bus.done, bus.volume};
         exv = {12'(e.beat), 2'(e.trk), e.en, e.dn, 2'(e.vol)};
         vectors++;
         assert (obs === exv && e.cyc == cyc) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got beat=%0d trk=%0d en=%0b done=%0b vol=%0d expected beat=%0d trk=%0d en=%0b done=%0b vol=%0d (due cyc %0d)",
                   e.tag, cyc, obs[17:6], obs[5:4], obs[3], obs[2], obs[1:0],
                   e.beat, e.trk, e.en, e.dn, e.vol, e.cyc);
         end
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk22);
         #1;
         cyc++;
         check_due();
      end
   endtask

   initial begin
      cyc         = 0;
      vectors     = 0;
      miscompares = 0;
      rst           = 1'b1;
      bus.play      = 1'b0;
      bus.pause     = 1'b0;
      bus.loop      = 1'b0;
      bus.track_sel = '0;
      bus.tempo     = '0;
      bus.vol_in    = 2'd0;

      // Reset state
      #2;
      push(0, "rst_state", 0, 0, 0, 0, 0);
      check_due();
      push(1, "rst_hold", 0, 0, 0, 0, 0);
      push(2, "rst_hold", 0, 0, 0, 0, 0);
      run(2);
      rst = 1'b0;
      push(1, "idle", 0, 0, 0, 0, 0);
      push(2, "idle", 0, 0, 0, 0, 0);
      run(2);

      // Track 0, tempo 0, loop: full 1200-beat pass with wrap and done
      bus.play = 1'b1; bus.track_sel = 2'd0; bus.tempo = 3'd0; bus.loop = 1'b1; bus.vol_in = 2'd2;
      push(1, "t1_sync", 0, 0, 0, 0, 0);
      push(2, "t1_sync", 0, 0, 0, 0, 2);
      for (int n = 0; n <= 1205; n++)
         push(3 + n, (n == 1200) ? "t1_wrap" : "t1_beat", n % 1200, 0, 1'b1, n == 1200,
              fv(2, n % 1200, 1199, 1'b1, 1'b1));
      run(3 + 1205);

      // Stop: rewind to IDLE after the sync latency
      bus.play = 1'b0;
      push(1, "t2_lat", 6, 0, 1, 0, 2);
      push(2, "t2_lat", 7, 0, 1, 0, 2);
      push(3, "t2_idle", 0, 0, 0, 0, 2);
      push(4, "t2_idle", 0, 0, 0, 0, 2);
      run(4);

      // Track 1, tempo 3, one-shot: every beat lasts 4 cycles, then DONE
      bus.play = 1'b1; bus.track_sel = 2'd1; bus.tempo = 3'd3; bus.loop = 1'b0; bus.vol_in = 2'd3;
      push(1, "t3_sync", 0, 0, 0, 0, 2);
      push(2, "t3_sync", 0, 0, 0, 0, 3);
      for (int k = 0; k < 270; k++) begin
         int b;
         b = (k / 4 > 63) ? 63 : k / 4;
         push(3 + k, (k == 256) ? "t3_done" : "t3_beat", b, 1, k < 256, k == 256,
              fv(3, b, 63, 1'b0, k < 256));
      end
      run(3 + 269);
      bus.play = 1'b0;
      push(1, "t3_hold", 63, 1, 0, 0, 3);
      push(2, "t3_hold", 63, 1, 0, 0, 3);
      push(3, "t3_idle", 0, 1, 0, 0, 3);
      run(3);

      // Pause at beat 10 with prescaler 2, tempo 3
      bus.play = 1'b1; bus.track_sel = 2'd0; bus.loop = 1'b1;
      push(1, "t4_sync", 0, 1, 0, 0, 3);
      push(2, "t4_sync", 0, 1, 0, 0, 3);
      for (int k = 0; k <= 42; k++)
         push(3 + k, "t4_run", k / 4, 0, 1, 0, 3);
      run(43);
      bus.pause = 1'b1;
      for (int j = 3; j <= 12; j++)
         push(j, "t4_pause", 10, 0, 0, 0, 3);
      run(12);
      bus.pause = 1'b0;
      push(1, "t4_held", 10, 0, 0, 0, 3);
      push(2, "t4_held", 10, 0, 0, 0, 3);
      push(3, "t4_resume", 10, 0, 1, 0, 3);
      push(4, "t4_resume", 10, 0, 1, 0, 3);
      push(5, "t4_beat11", 11, 0, 1, 0, 3);
      push(8, "t4_beat11", 11, 0, 1, 0, 3);
      push(9, "t4_beat12", 12, 0, 1, 0, 3);
      run(9);

      // Track change 0 -> 2 at beat 500, then 2 -> 3 exactly at end of track 2
      bus.play = 1'b0;
      push(3, "t5_idle", 0, 0, 0, 0, 3);
      run(3);
      bus.play = 1'b1; bus.tempo = 3'd0;
      push(1, "t5_sync", 0, 0, 0, 0, 3);
      push(2, "t5_sync", 0, 0, 0, 0, 3);
      for (int n = 0; n <= 500; n++)
         push(3 + n, "t5_run", n, 0, 1, 0, 3);
      run(503);
      bus.track_sel = 2'd2;
      push(1, "t5_lat", 501, 0, 1, 0, 3);
      push(2, "t5_lat", 502, 0, 1, 0, 3);
      push(3, "t5_chg", 0, 2, 1, 0, 3);
      for (int m = 1; m <= 510; m++)
         push(3 + m, "t5_trk2", m, 2, 1, 0, 3);
      run(512);
      bus.track_sel = 2'd3;
      push(2, "t5_last", 511, 2, 1, 0, 3);
      push(3, "t5_endchg", 0, 3, 1, 0, 3);
      push(4, "t5_trk3", 1, 3, 1, 0, 3);
      run(4);

      // Asynchronous reset at beat 300, restart with play held high
      bus.play = 1'b0;
      push(3, "t6_idle", 0, 3, 0, 0, 3);
      run(3);
      bus.play = 1'b1; bus.track_sel = 2'd0;
      push(1, "t6_sync", 0, 3, 0, 0, 3);
      push(2, "t6_sync", 0, 3, 0, 0, 3);
      for (int n = 0; n <= 300; n++)
         push(3 + n, "t6_run", n, 0, 1, 0, 3);
      run(303);
      #3;
      rst = 1'b1;
      #1;
      push(0, "t6_async", 0, 0, 0, 0, 0);
      check_due();
      push(1, "t6_inrst", 0, 0, 0, 0, 0);
      run(1);
      rst = 1'b0;
      push(1, "t6_rel", 0, 0, 0, 0, 0);
      push(2, "t6_rel", 0, 0, 0, 0, 3);
      push(3, "t6_restart", 0, 0, 1, 0, 3);
      push(4, "t6_restart", 1, 0, 1, 0, 3);
      push(5, "t6_restart", 2, 0, 1, 0, 3);
      run(5);

      vectors++;
      assert (sb.size() === 0) else begin
         miscompares++;
         $error("FAIL sb_drain got %0d pending entries expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
